// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the core's single memory port between the instruction fetch unit (IFU) and the
//   load/store unit (LSU). A three-state FSM grants one requester at a time. It registers the
//   address-select that steers the port's 2:1 address mux, and holds the grant until the memory
//   acknowledges or a timeout fires. A streak counter bounds consecutive LSU grants while the
//   IFU is waiting, so fetch cannot be starved.
//
// Ports
//   clk, rst_n               clock (rising edge), synchronous active-low reset
//   ifu_req, ifu_addr        IFU read request and address (held until ifu_done)
//   lsu_req, lsu_we,         LSU request, write enable, address and store data
//   lsu_addr, lsu_wdata      (held until lsu_done)
//   mem_ready, mem_rdata     memory acknowledge and read data
//   mem_valid, mem_we,       memory port: access in progress, write strobe, muxed address,
//   mem_addr, mem_wdata      store data
//   addr_sel                 registered mux control, 0 = IFU, 1 = LSU
//   ifu_done, ifu_rdata      IFU completion pulse and read data
//   lsu_done, lsu_rdata      LSU completion pulse and read data
//   bus_err                  timeout pulse, coincident with the done pulse
module mem_port_arbiter #(
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ifu_req,
    input  logic [BIT_WIDTH-1:0] ifu_addr,
    input  logic                 lsu_req,
    input  logic                 lsu_we,
    input  logic [BIT_WIDTH-1:0] lsu_addr,
    input  logic [BIT_WIDTH-1:0] lsu_wdata,
    input  logic                 mem_ready,
    input  logic [BIT_WIDTH-1:0] mem_rdata,
    output logic                 mem_valid,
    output logic                 mem_we,
    output logic [BIT_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0] mem_wdata,
    output logic                 addr_sel,
    output logic                 ifu_done,
    output logic                 lsu_done,
    output logic [BIT_WIDTH-1:0] ifu_rdata,
    output logic [BIT_WIDTH-1:0] lsu_rdata,
    output logic                 bus_err
);

    localparam int unsigned STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam int unsigned TIMER_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StBusyIf = 2'd1;
    localparam logic [1:0] StBusyLs = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                addr_sel_q, addr_sel_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;

    logic busy;
    logic timer_expired;
    logic finish;
    logic lsu_wins;

    assign busy          = (state_q == StBusyIf) || (state_q == StBusyLs);
    assign timer_expired = (timer_q == TIMER_LAST);
    // mem_ready on the last timer cycle wins over the timeout.
    assign finish        = busy && (mem_ready || timer_expired);
    // The IFU only blocks the LSU once the LSU has used up its streak allowance.
    assign lsu_wins      = lsu_req && (!ifu_req || (streak_q < STREAK_MAX));

    always_comb begin
        state_d    = state_q;
        addr_sel_d = addr_sel_q;
        streak_d   = streak_q;
        timer_d    = timer_q;

        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (lsu_wins) begin
                    state_d    = StBusyLs;
                    addr_sel_d = 1'b1;
                    if (!ifu_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (ifu_req) begin
                    state_d    = StBusyIf;
                    addr_sel_d = 1'b0;
                    streak_d   = '0;
                end
            end
            StBusyIf, StBusyLs: begin
                if (finish) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_sel_q <= 1'b0;
            streak_q   <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_sel_q <= addr_sel_d;
            streak_q   <= streak_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        mem_valid = busy;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ifu_done  = 1'b0;
        lsu_done  = 1'b0;
        ifu_rdata = '0;
        lsu_rdata = '0;
        bus_err   = busy && timer_expired && !mem_ready;

        if (busy) begin
            mem_addr = addr_sel_q ? lsu_addr : ifu_addr;
        end

        case (state_q)
            StBusyIf: begin
                ifu_done = finish;
                if (mem_ready) begin
                    ifu_rdata = mem_rdata;
                end
            end
            StBusyLs: begin
                mem_we    = lsu_we;
                mem_wdata = lsu_wdata;
                lsu_done  = finish;
                if (mem_ready) begin
                    lsu_rdata = mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign addr_sel = addr_sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A behavioural model tracks the port owner, the
//   wait count and the LSU streak, and every output is compared against it on each falling edge.
//   Directed scenarios add hand-computed literal expectations.
module tb_mem_port_arbiter;

    localparam int BW = 32;
    localparam int MS = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifu_req, lsu_req, lsu_we, mem_ready;
    logic [BW-1:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic          mem_valid, mem_we, addr_sel, ifu_done, lsu_done, bus_err;
    logic [BW-1:0] mem_addr, mem_wdata, ifu_rdata, lsu_rdata;

    mem_port_arbiter #(
        .BIT_WIDTH (BW),
        .MAX_STREAK(MS),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ifu_req  (ifu_req),
        .ifu_addr (ifu_addr),
        .lsu_req  (lsu_req),
        .lsu_we   (lsu_we),
        .lsu_addr (lsu_addr),
        .lsu_wdata(lsu_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .addr_sel (addr_sel),
        .ifu_done (ifu_done),
        .lsu_done (lsu_done),
        .ifu_rdata(ifu_rdata),
        .lsu_rdata(lsu_rdata),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: owner 0 = nobody, 1 = IFU, 2 = LSU.
    int  owner   = 0;
    bit  sel     = 1'b0;
    int  streak  = 0;
    int  waited  = 0;
    bit  known   = 1'b0;
    int  n_ifu_done = 0;
    int  n_lsu_done = 0;
    int  n_err      = 0;
    bit  log_en  = 1'b0;
    byte glog[$];

    bit          m_busy, m_fin, m_err;
    logic [31:0] m_addr;

    always @(negedge clk) begin
        m_busy = (owner != 0);
        m_fin  = m_busy && (mem_ready || waited == TO - 1);
        m_err  = m_busy && !mem_ready && waited == TO - 1;
        m_addr = !m_busy ? 32'h0 : (sel ? lsu_addr : ifu_addr);
        if (known) begin
            chk("mem_valid", mem_valid, m_busy);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, (owner == 2) ? lsu_we : 1'b0);
            chk("mem_wdata", mem_wdata, (owner == 2) ? lsu_wdata : 32'h0);
            chk("addr_sel", addr_sel, sel);
            chk("ifu_done", ifu_done, owner == 1 && m_fin);
            chk("lsu_done", lsu_done, owner == 2 && m_fin);
            chk("ifu_rdata", ifu_rdata, (owner == 1 && mem_ready) ? mem_rdata : 32'h0);
            chk("lsu_rdata", lsu_rdata, (owner == 2 && mem_ready) ? mem_rdata : 32'h0);
            chk("bus_err", bus_err, m_err);
        end
        if (ifu_done === 1'b1) n_ifu_done++;
        if (lsu_done === 1'b1) n_lsu_done++;
        if (bus_err === 1'b1) n_err++;
        if (log_en && ifu_done === 1'b1) glog.push_back("I");
        if (log_en && lsu_done === 1'b1) glog.push_back("L");

        if (!rst_n) begin
            owner = 0; sel = 1'b0; streak = 0; waited = 0; known = 1'b1;
        end else if (owner == 0) begin
            if (lsu_req && (!ifu_req || streak < MS)) begin
                owner = 2; sel = 1'b1; waited = 0;
                streak = ifu_req ? ((streak + 1 > MS) ? MS : streak + 1) : 0;
            end else if (ifu_req) begin
                owner = 1; sel = 1'b0; waited = 0; streak = 0;
            end
        end else if (m_fin) begin
            owner = 0;
        end else begin
            waited++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int    base_i, base_l, base_e;
    string exp_seq;

    initial begin
        rst_n = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; mem_ready = 1'b0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; mem_rdata = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_addr_sel", addr_sel, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_done", {ifu_done, lsu_done, bus_err}, 0);

        // 1: reset while an LSU access is in flight
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h0000_3000; lsu_wdata = 32'h55;
        cyc();
        #1;
        chk("t1_busy_valid", mem_valid, 1);
        chk("t1_busy_sel", addr_sel, 1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0;
        #1;
        chk("t1_valid_after_rst", mem_valid, 0);
        chk("t1_sel_after_rst", addr_sel, 0);
        cyc();
        chk("t1_no_lsu_done", n_lsu_done, 0);

        // 2: IFU alone, memory answers on the third busy cycle
        base_i = n_ifu_done;
        ifu_req = 1'b1; ifu_addr = 32'h0000_0100; mem_rdata = 32'h0000_0013;
        cyc();
        cyc();
        cyc();
        mem_ready = 1'b1;
        #1;
        chk("t2_ifu_done", ifu_done, 1);
        chk("t2_ifu_rdata", ifu_rdata, 32'h0000_0013);
        chk("t2_addr_sel", addr_sel, 0);
        chk("t2_mem_addr", mem_addr, 32'h0000_0100);
        chk("t2_mem_we", mem_we, 0);
        cyc();
        ifu_req = 1'b0; mem_ready = 1'b0;
        cyc();
        chk("t2_done_once", n_ifu_done - base_i, 1);

        // 3: LSU store alone, zero-wait memory
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h0000_2000; lsu_wdata = 32'hDEAD_BEEF;
        mem_ready = 1'b1; mem_rdata = '0;
        cyc();
        #1;
        chk("t3_mem_we", mem_we, 1);
        chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t3_mem_addr", mem_addr, 32'h0000_2000);
        chk("t3_addr_sel", addr_sel, 1);
        chk("t3_lsu_done", lsu_done, 1);
        cyc();
        lsu_req = 1'b0; lsu_we = 1'b0; mem_ready = 1'b0;
        cyc();

        // 4a: both requesters held, zero-wait memory
        glog.delete();
        log_en = 1'b1;
        ifu_req = 1'b1; lsu_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000_A5A5;
        ifu_addr = 32'h0000_0104; lsu_addr = 32'h0000_2004;
        repeat (20) cyc();
        ifu_req = 1'b0; lsu_req = 1'b0; log_en = 1'b0;
        exp_seq = "LLLLILLLLI";
        chk("t4_grant_count", glog.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < glog.size()) chk($sformatf("t4_grant_%0d", i), glog[i], exp_seq[i]);
        end
        cyc();

        // 4b: IFU alone, granted every other cycle
        base_i = n_ifu_done;
        ifu_req = 1'b1;
        repeat (8) cyc();
        ifu_req = 1'b0; mem_ready = 1'b0;
        chk("t4b_ifu_grants", n_ifu_done - base_i, 4);
        cyc();

        // 5: timeout on the 16th busy cycle
        base_l = n_lsu_done; base_e = n_err;
        lsu_req = 1'b1; lsu_we = 1'b0; mem_rdata = 32'hBAD0_BAD0;
        repeat (15) cyc();
        #1;
        chk("t5_no_early_done", lsu_done, 0);
        chk("t5_no_early_err", bus_err, 0);
        cyc();
        #1;
        chk("t5_lsu_done", lsu_done, 1);
        chk("t5_bus_err", bus_err, 1);
        chk("t5_lsu_rdata", lsu_rdata, 0);
        cyc();
        lsu_req = 1'b0;
        #1;
        chk("t5_idle", mem_valid, 0);
        chk("t5_one_done", n_lsu_done - base_l, 1);
        chk("t5_one_err", n_err - base_e, 1);
        cyc();

        // 6: mem_ready on the 16th busy cycle beats the timeout
        ifu_req = 1'b1; ifu_addr = 32'h0000_0200; mem_rdata = 32'h1234_5678;
        repeat (16) cyc();
        mem_ready = 1'b1;
        #1;
        chk("t6_ifu_done", ifu_done, 1);
        chk("t6_ifu_rdata", ifu_rdata, 32'h1234_5678);
        chk("t6_no_err", bus_err, 0);
        cyc();
        ifu_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("t6_idle", mem_valid, 0);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
